// File: rtl/button_event_ctrl.sv
// Debounced button input block with edge capture and a level interrupt, exposed as a
// small four-register slave.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high reset
//   address    - register select: 0 levels (RO), 1 edge_sel, 2 irq_mask, 3 edge_capture (W1C)
//   chipselect - slave access qualifier
//   write_n    - active-low write strobe
//   writedata  - write data; only [WIDTH-1:0] is used
//   in_port    - raw asynchronous button levels (active-low)
//   readdata   - registered read data, zero-extended, 1-cycle latency
//   irq        - OR of (edge_capture & irq_mask)
module button_event_ctrl #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {StStable, StSettling} state_e;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CntW-1:0]  cnt_q   [WIDTH];
  logic [CntW-1:0]  cnt_d   [WIDTH];

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] cap_q, cap_d, cap_set, cap_clr;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_d;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Per-bit debounce FSM: a new level must be seen for DEBOUNCE_CYCLES+1 consecutive
  // edges (entry edge plus counter 1..DEBOUNCE_CYCLES) before the debounced bit flips.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        StStable: begin
          if (sync2_q[i] != db_q[i]) begin
            state_d[i] = StSettling;
            cnt_d[i]   = CntW'(1);
          end
        end
        StSettling: begin
          if (sync2_q[i] == db_q[i]) begin
            state_d[i] = StStable;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES)) begin
            toggle[i]  = 1'b1;
            state_d[i] = StStable;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CntW'(1);
          end
        end
        default: begin
          state_d[i] = StStable;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    db_d    = db_q ^ toggle;
    // New level equals ~db_q; capture when it matches edge_sel (0 press, 1 release).
    cap_set = toggle & (db_q ^ sel_q);
    cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // Set wins over a simultaneous W1C of the same bit.
    cap_d   = (cap_q & ~cap_clr) | cap_set;
    sel_d   = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : sel_q;
    mask_d  = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = db_q;
      2'd1:    readdata_d[WIDTH-1:0] = sel_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      db_q     <= IDLE_LEVEL;
      cap_q    <= '0;
      sel_q    <= '0;
      mask_q   <= '0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= StStable;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cap_q    <= cap_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      readdata <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign irq = |(cap_q & mask_q);

endmodule
